// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and width helpers for the sequence-scan controller
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} scan_state_t;
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction
endpackage

// File: rtl/seq_scan_controller_if.sv
// seq_scan_controller_if: valid/ready word stream into the scan controller
interface seq_scan_controller_if #(parameter int WORD_W = 8);
  logic              valid;
  logic              ready;
  logic [WORD_W-1:0] data;
  modport master(output valid, data, input ready);
  modport slave(input valid, data, output ready);
endinterface

// File: rtl/seq_pattern_matcher.sv
// seq_pattern_matcher: serial history and programmable-length pattern compare
module seq_pattern_matcher #(
  parameter int MAX_PAT_LEN = 8,
  parameter int LEN_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   bit_in,
  input  logic [MAX_PAT_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]       len,
  input  logic                   overlap,
  input  logic                   clr,
  output logic                   match
);
  logic [MAX_PAT_LEN-1:0] hist, hist_next, mask;
  logic [MAX_PAT_LEN:0]   mask_w;
  logic [LEN_W-1:0]       fill, fill_next;
  // match looks at the history including the bit being shifted this cycle
  always_comb begin
    hist_next = {hist[MAX_PAT_LEN-2:0], bit_in};
    fill_next = fill == LEN_W'(MAX_PAT_LEN) ? fill : fill + LEN_W'(1);
    mask_w = ((MAX_PAT_LEN+1)'(1) << len) - (MAX_PAT_LEN+1)'(1);
    mask = mask_w[MAX_PAT_LEN-1:0];
    match = en && fill_next >= len && ((hist_next ^ pattern) & mask) == '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= hist_next;
      fill <= match && !overlap ? '0 : fill_next;
    end
  end
endmodule

// File: rtl/seq_scan_controller.sv
// seq_scan_controller: serialises streamed words into a programmable pattern matcher
module seq_scan_controller
  import seq_det_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int MAX_PAT_LEN = 8,
  parameter int CNT_W = 8,
  parameter int LEN_W = len_w(MAX_PAT_LEN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [MAX_PAT_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   cfg_overlap,
  input  logic                   start,
  input  logic                   stop,
  seq_scan_controller_if.slave   s,
  output logic                   busy,
  output logic                   match_pulse,
  output logic [CNT_W-1:0]       match_count,
  output logic                   cfg_err
);
  localparam int IDX_W = $clog2(WORD_W);
  scan_state_t            state;
  logic [WORD_W-1:0]      word;
  logic [IDX_W-1:0]       bit_idx;
  logic                   stop_pending, ovl, match, last, hs, cfg_ok;
  logic [MAX_PAT_LEN-1:0] pat;
  logic [LEN_W-1:0]       len;
  assign last = state == SHIFT && bit_idx == '0;
  assign s.ready = state == LOAD || (last && !stop_pending && !stop);
  assign hs = s.valid && s.ready;
  assign busy = state != IDLE;
  assign cfg_ok = cfg_len != '0 && cfg_len <= LEN_W'(MAX_PAT_LEN);
  seq_pattern_matcher #(.MAX_PAT_LEN(MAX_PAT_LEN), .LEN_W(LEN_W)) u_matcher (
    .clk(clk),
    .reset(reset),
    .en(state == SHIFT),
    .bit_in(word[bit_idx]),
    .pattern(pat),
    .len(len),
    .overlap(ovl),
    .clr(state == IDLE && start),
    .match(match)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      word <= '0;
      bit_idx <= '0;
      stop_pending <= 1'b0;
      pat <= '0;
      len <= LEN_W'(1);
      ovl <= 1'b1;
      match_pulse <= 1'b0;
      match_count <= '0;
      cfg_err <= 1'b0;
    end else begin
      match_pulse <= match;
      if (match && match_count != '1) match_count <= match_count + CNT_W'(1);
      if (busy && cfg_we) cfg_err <= 1'b1;
      case (state)
        IDLE:
          if (start) begin
            state <= LOAD;
            match_count <= '0;
            cfg_err <= 1'b0;
            stop_pending <= 1'b0;
          end else if (cfg_we) begin
            if (cfg_ok) begin
              pat <= cfg_pattern;
              len <= cfg_len;
              ovl <= cfg_overlap;
            end else cfg_err <= 1'b1;
          end
        LOAD:
          if (hs) begin
            word <= s.data;
            bit_idx <= IDX_W'(WORD_W - 1);
            stop_pending <= stop;
            state <= SHIFT;
          end else if (stop) state <= IDLE;
        SHIFT: begin
          bit_idx <= bit_idx - IDX_W'(1);
          if (stop) stop_pending <= 1'b1;
          // last bit: honour stop, or reload for back-to-back words
          if (last) begin
            if (stop_pending || stop) begin
              state <= IDLE;
              stop_pending <= 1'b0;
            end else if (hs) begin
              word <= s.data;
              bit_idx <= IDX_W'(WORD_W - 1);
            end else state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_scan_controller.sv
// tb_seq_scan_controller: directed scans checked against a bit-queue reference model
module tb_seq_scan_controller;
  localparam int W = 8, M = 8, C = 8, LW = 4;
  logic clk = 0, reset = 0, cfg_we = 0, cfg_overlap = 0, start = 0, stop = 0;
  logic [M-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic busy, match_pulse, cfg_err;
  logic [C-1:0] match_count;
  int total = 0, bad = 0, npulse = 0, cyc = 0;
  bit m_busy = 0, m_err = 0, m_pulse = 0, m_stop_req = 0, m_ovl = 1;
  int m_count = 0, m_len = 1;
  logic [M-1:0] m_pat = '0;
  bit bits[$];
  bit hist[$];
  seq_scan_controller_if #(.WORD_W(W)) s();
  seq_scan_controller #(.WORD_W(W), .MAX_PAT_LEN(M), .CNT_W(C)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .start(start), .stop(stop),
    .s(s), .busy(busy), .match_pulse(match_pulse), .match_count(match_count),
    .cfg_err(cfg_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic bit m_ready();
    return m_busy && (bits.size() == 0 || (bits.size() == 1 && !m_stop_req && !stop));
  endfunction
  function automatic bit hit();
    if (hist.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (hist[hist.size()-1-i] != m_pat[i]) return 0;
    return 1;
  endfunction
  task automatic m_load();
    for (int i = W - 1; i >= 0; i--) bits.push_back(s.data[i]);
  endtask
  task automatic m_step();
    bit hs;
    hs = s.valid && m_ready();
    m_pulse = 0;
    if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_count = 0; m_err = 0; m_stop_req = 0;
        hist.delete();
      end else if (cfg_we) begin
        if (cfg_len >= 1 && cfg_len <= M) begin
          m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        end else m_err = 1;
      end
    end else begin
      if (cfg_we) m_err = 1;
      if (bits.size() == 0) begin
        if (hs) begin m_load(); m_stop_req = stop; end
        else if (stop) m_busy = 0;
      end else begin
        hist.push_back(bits.pop_front());
        if (hist.size() > M) void'(hist.pop_front());
        if (hit()) begin
          m_pulse = 1;
          if (m_count < (1 << C) - 1) m_count++;
          if (!m_ovl) hist.delete();
        end
        if (stop) m_stop_req = 1;
        if (bits.size() == 0) begin
          if (m_stop_req) begin m_busy = 0; m_stop_req = 0; end
          else if (hs) m_load();
        end
      end
    end
  endtask
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_busy = 0; m_err = 0; m_pulse = 0; m_stop_req = 0; m_count = 0;
      m_pat = '0; m_len = 1; m_ovl = 1;
      bits.delete(); hist.delete();
    end else m_step();
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(negedge clk);
    chk("s_ready", s.ready, m_ready());
    chk("busy", busy, m_busy);
    chk("match_pulse", match_pulse, m_pulse);
    chk("match_count", match_count, m_count);
    chk("cfg_err", cfg_err, m_err);
    if (match_pulse) npulse++;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic cfg(input logic [M-1:0] p, input int l, input bit o);
    cfg_we = 1; cfg_pattern = p; cfg_len = LW'(l); cfg_overlap = o;
    step();
    cfg_we = 0;
  endtask
  task automatic go();
    start = 1;
    step();
    start = 0;
    npulse = 0;
  endtask
  task automatic send(input logic [W-1:0] w, output int at);
    s.valid = 1; s.data = w; at = -1;
    for (int i = 0; i < 40; i++) begin
      if (s.ready) begin
        step();
        at = cyc;
        break;
      end
      step();
    end
    s.valid = 0;
    chk("handshake_seen", int'(at >= 0), 1);
  endtask
  task automatic finish(output int n);
    stop = 1;
    step();
    stop = 0;
    n = 1;
    while (busy && n < 40) begin step(); n++; end
    chk("idle_reached", busy, 0);
  endtask
  initial begin
    int a, b, n;
    s.valid = 0; s.data = '0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_count", match_count, 0);
    reset = 1;
    step();
    cfg(8'h06, 4, 1); go(); send(8'h36, a); finish(n);
    chk("t1_cycles", n, 8); chk("t1_pulses", npulse, 2); chk("t1_count", match_count, 2);
    cfg(8'h06, 4, 0); go(); send(8'h36, a); finish(n);
    chk("t2_pulses", npulse, 1); chk("t2_count", match_count, 1);
    cfg(8'h06, 4, 1); go(); send(8'h36, a); send(8'h36, b);
    chk("t3_gap", b - a, 8);
    finish(n);
    chk("t3_pulses", npulse, 4); chk("t3_count", match_count, 4);
    go(); send(8'h36, a);
    step(); step();
    stop = 1; step(); stop = 0;
    n = 3;
    while (busy && n < 40) begin step(); n++; end
    chk("t4_stop_cycles", n, 8); chk("t4_count", match_count, 2);
    go(); send(8'h36, a);
    cfg(8'hFF, 1, 0);
    chk("t5_busy_err", cfg_err, 1);
    finish(n);
    chk("t5_sticky", cfg_err, 1);
    cfg(8'hFF, 0, 0);
    chk("t5_len0_err", cfg_err, 1);
    cfg(8'hFF, 9, 0);
    go();
    chk("t5_start_clr", cfg_err, 0);
    send(8'h36, a); finish(n);
    chk("t5_cfg_kept", match_count, 2);
    cfg(8'h01, 1, 1); go();
    for (int i = 0; i < 33; i++) send(8'hFF, a);
    finish(n);
    chk("t6_sat_count", match_count, 255); chk("t6_pulses", npulse, 264);
    go(); send(8'hFF, a);
    step(); step(); step();
    chk("t7_pre_count", match_count, 3);
    reset = 0;
    #1;
    chk("t7_busy", busy, 0); chk("t7_ready", s.ready, 0); chk("t7_pulse", match_pulse, 0);
    chk("t7_count", match_count, 0); chk("t7_err", cfg_err, 0);
    step();
    reset = 1;
    step();
    go();
    chk("t7_load_ready", s.ready, 1);
    send(8'h0F, a); finish(n);
    chk("t7_default_cfg", match_count, 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
